// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-RAM arbiter.
// Holds the FSM state encoding, the port index constants and the beat counter width.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    function automatic int beat_cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Next-owner selection for the data-RAM arbiter (ARB_FIXED_PRIO_EN selects fixed A priority).
// Latency: purely combinational.
// Backpressure: none; a losing requester simply stays ungranted.
module arb_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] state,
    input  logic       a_req,
    input  logic       b_req,
    input  logic       last_owner,
    input  logic       expired,
    output logic [1:0] next_state
);

    always_comb begin
        next_state = IDLE;
        case (state)
            OWN_A: begin
                if (!a_req)
                    next_state = b_req ? OWN_B : IDLE;
`ifdef ARB_FIXED_PRIO_EN
                // The core is never cut off: A holds the RAM while it keeps asking.
                else
                    next_state = OWN_A;
`else
                else if (expired && b_req)
                    next_state = OWN_B;
                else
                    next_state = OWN_A;
`endif
            end
            OWN_B: begin
                if (!b_req)
                    next_state = a_req ? OWN_A : IDLE;
                else if (expired && a_req)
                    next_state = OWN_A;
                else
                    next_state = OWN_B;
            end
            default: begin
                if (a_req && b_req)
`ifdef ARB_FIXED_PRIO_EN
                    next_state = OWN_A;
`else
                    next_state = (last_owner == PORT_B) ? OWN_A : OWN_B;
`endif
                else if (a_req)
                    next_state = OWN_A;
                else if (b_req)
                    next_state = OWN_B;
                else
                    next_state = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing one data RAM between core (A) and loader (B); macro ARB_FIXED_PRIO_EN.
// Latency: grant one cycle after req from idle, read data valid one cycle after the beat.
// Backpressure: a requester waits with req high until its registered grant arrives.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int               CNT_W     = beat_cnt_w(MAX_BURST);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_t       state, state_nxt;
    logic [1:0]       pick_state;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
    logic             last_owner, last_owner_nxt;
    logic             a_beat, b_beat, own_beat, expired;

    assign a_beat   = a_req && (state == OWN_A);
    assign b_beat   = b_req && (state == OWN_B);
    assign own_beat = a_beat || b_beat;
    // The current beat is the last one the owner is entitled to in this burst.
    assign expired  = own_beat && (beat_cnt == LAST_BEAT);

    arb_pick u_pick (
        .state      (state),
        .a_req      (a_req),
        .b_req      (b_req),
        .last_owner (last_owner),
        .expired    (expired),
        .next_state (pick_state)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            last_owner <= PORT_B;
        end else begin
            state      <= state_nxt;
            beat_cnt   <= beat_cnt_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    always_comb begin
        state_nxt      = arb_state_t'(pick_state);
        beat_cnt_nxt   = beat_cnt;
        last_owner_nxt = last_owner;
        if (state_nxt != state) begin
            beat_cnt_nxt = '0;
            if (state_nxt == OWN_A)
                last_owner_nxt = PORT_A;
            else if (state_nxt == OWN_B)
                last_owner_nxt = PORT_B;
        end else if (own_beat) begin
            beat_cnt_nxt = expired ? '0 : beat_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        a_gnt     = (state == OWN_A);
        b_gnt     = (state == OWN_B);
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        if (a_beat) begin
            ram_addr  = a_addr;
            ram_wdata = a_wdata;
            ram_we    = a_we;
        end else if (b_beat) begin
            ram_addr  = b_addr;
            ram_wdata = b_wdata;
            ram_we    = b_we;
        end
    end

    // Read data tracks the RAM one cycle behind the beat; reset kills any read in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= a_beat && !a_we;
            b_rvalid <= b_beat && !b_we;
        end
    end

    assign a_rdata = ram_rdata;
    assign b_rdata = ram_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked every cycle against an ownership/burst model and a shadow memory.
module tb_dmem_arbiter;

    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we;
    logic [DW-1:0] a_rdata, b_rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;

    logic [DW-1:0] ram   [256];
    logic [DW-1:0] m_mem [256];

    int            n_chk = 0;
    int            n_pass = 0;

    // Model: owner 0 = nobody, 1 = A, 2 = B; m_cnt = beats taken in current burst.
    int            m_owner = 0;
    int            m_cnt = 0;
    int            m_last = 2;
    bit            m_rva = 1'b0, m_rvb = 1'b0;
    logic [DW-1:0] m_rd = '0;
    bit            chk_en = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .a_gnt     (a_gnt),
        .a_rvalid  (a_rvalid),
        .a_rdata   (a_rdata),
        .b_gnt     (b_gnt),
        .b_rvalid  (b_rvalid),
        .b_rdata   (b_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]   <= (i * 32'h0101_0101) ^ 32'h5A5A_0000;
            m_mem[i]  = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
        end
    end

    always @(posedge clk) begin
        ram_rdata <= ram[ram_addr];
        if (ram_we)
            ram[ram_addr] <= ram_wdata;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic bit rq(input int p);
        return (p == 1) ? a_req : b_req;
    endfunction

    function automatic bit limited(input int p);
`ifdef ARB_FIXED_PRIO_EN
        return p == 2;
`else
        return p != 0;
`endif
    endfunction

    // Compare this cycle's outputs, then advance the model with the inputs the DUT
    // will sample at the next rising edge (inputs are stable from posedge+1 onward).
    always @(negedge clk) begin
        bit            ab, bb;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        int            nxt, x, y;
        ab = a_req && (m_owner == 1);
        bb = b_req && (m_owner == 2);
        e_we = 1'b0; e_addr = '0; e_wd = '0;
        if (ab) begin e_we = a_we; e_addr = a_addr; e_wd = a_wdata; end
        else if (bb) begin e_we = b_we; e_addr = b_addr; e_wd = b_wdata; end
        if (chk_en) begin
            chk("a_gnt", a_gnt, m_owner == 1);
            chk("b_gnt", b_gnt, m_owner == 2);
            chk("ram_we", ram_we, e_we);
            chk("ram_addr", ram_addr, e_addr);
            chk("ram_wdata", ram_wdata, e_wd);
            chk("a_rvalid", a_rvalid, m_rva);
            chk("b_rvalid", b_rvalid, m_rvb);
            if (m_rva) chk("a_rdata", a_rdata, m_rd);
            if (m_rvb) chk("b_rdata", b_rdata, m_rd);
        end
        if (ab && a_we) m_mem[a_addr] = a_wdata;
        if (bb && b_we) m_mem[b_addr] = b_wdata;
        if (reset) begin
            m_owner = 0; m_cnt = 0; m_last = 2; m_rva = 0; m_rvb = 0;
            chk_en = 1'b1;
        end else begin
            m_rva = ab && !a_we;
            m_rvb = bb && !b_we;
            if (m_rva) m_rd = m_mem[a_addr];
            if (m_rvb) m_rd = m_mem[b_addr];
            nxt = m_owner;
            if (m_owner == 0) begin
`ifdef ARB_FIXED_PRIO_EN
                if (a_req && b_req) nxt = 1;
`else
                if (a_req && b_req) nxt = 3 - m_last;
`endif
                else if (a_req) nxt = 1;
                else if (b_req) nxt = 2;
            end else begin
                x = m_owner;
                y = 3 - x;
                if (!rq(x)) begin
                    nxt = rq(y) ? y : 0;
                end else begin
                    m_cnt++;
                    if (limited(x) && m_cnt >= MAXB) begin
                        if (rq(y)) nxt = y;
                        else m_cnt = 0;
                    end
                end
            end
            if (nxt != m_owner) begin
                m_cnt = 0;
                if (nxt != 0) m_last = nxt;
            end
            m_owner = nxt;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic obs();
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc();
        reset = 1'b1; a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        int  nb;
        bit  exp_a;

        // Reset values, then A writes and B reads the same word back.
        do_reset();
        obs();
        chk("rst_a_gnt", a_gnt, 1'b0);
        chk("rst_b_gnt", b_gnt, 1'b0);
        chk("rst_a_rvalid", a_rvalid, 1'b0);
        chk("rst_b_rvalid", b_rvalid, 1'b0);
        chk("rst_ram_we", ram_we, 1'b0);
        cyc(); a_req = 1; a_we = 1; a_addr = 8'h10; a_wdata = 32'hDEAD_BEEF;
        obs(); chk("t1_gnt_c0", a_gnt, 1'b0);
        cyc();
        obs();
        chk("t1_gnt_c1", a_gnt, 1'b1);
        chk("t1_we_c1", ram_we, 1'b1);
        chk("t1_addr_c1", ram_addr, 8'h10);
        cyc(); a_req = 0; a_we = 0; b_req = 1; b_we = 0; b_addr = 8'h10;
        obs();
        cyc();
        obs(); chk("t1_bgnt", b_gnt, 1'b1);
        cyc(); b_req = 0;
        obs();
        chk("t1_b_rvalid", b_rvalid, 1'b1);
        chk("t1_b_rdata", b_rdata, 32'hDEAD_BEEF);
        cyc(); cyc();

        // Tie from idle: A first, B straight after A lets go.
        do_reset();
        cyc(); a_req = 1; b_req = 1; a_we = 0; b_we = 0; a_addr = 8'h3; b_addr = 8'h4;
        obs();
        cyc(); obs();
        chk("t2_a_first", a_gnt, 1'b1);
        chk("t2_b_wait", b_gnt, 1'b0);
        cyc(); obs();
        cyc(); a_req = 0; obs();
        cyc(); obs();
        chk("t2_b_next", b_gnt, 1'b1);
        chk("t2_a_off", a_gnt, 1'b0);
        cyc(); b_req = 0;
        cyc();

        // Both requesting continuously: burst alternation without bubbles.
        do_reset();
        cyc(); a_req = 1; b_req = 1; a_addr = 8'h20; b_addr = 8'h21;
        obs();
        for (int k = 1; k < 20; k++) begin
            cyc(); obs();
`ifdef ARB_FIXED_PRIO_EN
            exp_a = 1'b1;
`else
            exp_a = (((k - 1) / MAXB) % 2) == 0;
`endif
            chk($sformatf("t3_a_gnt_c%0d", k), a_gnt, exp_a);
            chk($sformatf("t3_b_gnt_c%0d", k), b_gnt, !exp_a);
        end
        cyc(); a_req = 0; b_req = 0;
        cyc(); cyc();

        // Single requester keeps the grant across burst expiry.
        do_reset();
        cyc(); a_req = 1; a_we = 0; a_addr = 8'h30;
        obs();
        nb = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc(); obs();
            if (a_req && a_gnt) nb++;
        end
        cyc(); a_req = 0;
        chk("t4_beats", nb, 10);
        cyc(); cyc();

        // Reset asserted in the same cycle as a read beat.
        do_reset();
        cyc(); a_req = 1; a_we = 0; a_addr = 8'h40;
        obs();
        cyc(); reset = 1;
        obs(); chk("t5_beat_n", a_gnt, 1'b1);
        cyc(); reset = 0;
        obs();
        chk("t5_rvalid", a_rvalid, 1'b0);
        chk("t5_a_gnt", a_gnt, 1'b0);
        chk("t5_b_gnt", b_gnt, 1'b0);
        cyc(); a_req = 0;
        cyc(); cyc();

`ifdef ARB_FIXED_PRIO_EN
        // Fixed priority: B starves until A drops its request.
        do_reset();
        cyc(); a_req = 1; b_req = 1;
        nb = 0;
        for (int k = 0; k < 30; k++) begin
            obs();
            if (b_gnt) nb++;
            cyc();
        end
        a_req = 0;
        obs();
        cyc(); obs();
        chk("t6_b_starved", nb, 0);
        chk("t6_b_after", b_gnt, 1'b1);
        cyc(); b_req = 0;
        cyc();
`endif

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            cyc();
            reset   = ($urandom_range(0, 199) == 0);
            a_req   = ($urandom_range(0, 99) < 65);
            b_req   = ($urandom_range(0, 99) < 55);
            a_we    = ($urandom_range(0, 2) == 0);
            b_we    = ($urandom_range(0, 2) == 0);
            a_addr  = AW'($urandom_range(0, 15));
            b_addr  = AW'($urandom_range(0, 15));
            a_wdata = $urandom();
            b_wdata = $urandom();
        end
        cyc();
        reset = 0; a_req = 0; b_req = 0;
        repeat (4) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
